cjb_risc_hmmiop_cu_v: RTL and testbench

CJB_RISC_HMMIOP_CU_V -- requirements
Module: cjb_risc_hmmiop_cu_v

---
 rtl/cjb_risc_hmmiop_cu_v.sv | 218 +++++++++++++++++++++
 tb/tb_cjb_risc_hmmiop_cu_v.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cjb_risc_hmmiop_cu_v.sv
// cjb_risc_hmmiop_cu_v: multicycle control unit for the HMMIOP RISC core.
// Moore/Mealy mix: state register plus combinational strobe decode.
module cjb_risc_hmmiop_cu_v #(
  parameter logic [9:0] IPDR_ADDR = 10'h3FF,
  parameter logic [9:0] OPDR_ADDR = 10'h3FE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] IW,
  input  logic [3:0] SR_CNVZ,
  input  logic [9:0] MARout,
  output logic       RST_PC,
  output logic       LD_PC,
  output logic       CNT_PC,
  output logic       LD_IR,
  output logic       LD_R0,
  output logic       LD_R1,
  output logic       LD_R2,
  output logic       LD_R3,
  output logic       LD_SR,
  output logic       LD_MABR,
  output logic       LD_MAXR,
  output logic       LD_MAR,
  output logic       RW,
  output logic       LD_IPDR,
  output logic       LD_OPDR,
  output logic       push,
  output logic       pop,
  output logic       ipstksel,
  output logic [1:0] IB0_SEL,
  output logic [1:0] IB1_SEL,
  output logic [1:0] IB2_SEL,
  output logic [3:0] ALU_FS,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_JCHK   = 4'd6,
    S_JLD    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_COPY  = 4'b0011;
  localparam logic [3:0] OP_STK   = 4'b1100;
  localparam logic [3:0] OP_JUMP  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1110;

  state_t     state_q, state_d;
  logic [3:0] op;
  logic [1:0] ri;
  logic [1:0] rj;
  logic [3:0] ld_r;
  logic       cond;
  logic       is_alu;

  assign op     = IW[7:4];
  assign ri     = IW[3:2];
  assign rj     = IW[1:0];
  assign is_alu = (op >= 4'd4) && (op <= 4'd11);

  // Branch condition: 1-4 test C/N/V/Z set, 5-8 test them clear
  always_comb begin
    cond = 1'b0;
    case (IW[3:0])
      4'd0:    cond = 1'b1;
      4'd1:    cond = SR_CNVZ[3];
      4'd2:    cond = SR_CNVZ[2];
      4'd3:    cond = SR_CNVZ[1];
      4'd4:    cond = SR_CNVZ[0];
      4'd5:    cond = ~SR_CNVZ[3];
      4'd6:    cond = ~SR_CNVZ[2];
      4'd7:    cond = ~SR_CNVZ[1];
      4'd8:    cond = ~SR_CNVZ[0];
      default: cond = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction immediately
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Next-state and control strobe decode
  always_comb begin
    state_d  = S_FETCH;
    RST_PC   = 1'b0;
    LD_PC    = 1'b0;
    CNT_PC   = 1'b0;
    LD_IR    = 1'b0;
    ld_r     = 4'b0000;
    LD_SR    = 1'b0;
    LD_MABR  = 1'b0;
    LD_MAXR  = 1'b0;
    LD_MAR   = 1'b0;
    RW       = 1'b0;
    LD_IPDR  = 1'b0;
    LD_OPDR  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    ipstksel = 1'b0;
    IB0_SEL  = 2'd0;
    IB1_SEL  = 2'd0;
    IB2_SEL  = 2'd0;
    ALU_FS   = 4'd0;
    case (state_q)
      S_RST: begin
        RST_PC  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        LD_IR   = 1'b1;
        CNT_PC  = 1'b1;
        LD_IPDR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_LOAD || op == OP_STORE) begin
          IB0_SEL = rj;
          LD_MABR = 1'b1;
          LD_MAXR = 1'b1;
          CNT_PC  = 1'b1;
          state_d = S_ADDR;
        end else if (op == OP_JUMP) begin
          LD_MABR = 1'b1;
          LD_MAXR = 1'b1;
          CNT_PC  = 1'b1;
          state_d = S_JCHK;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          IB0_SEL  = ri;
          IB1_SEL  = rj;
          IB2_SEL  = 2'd1;
          ALU_FS   = op - 4'd4;
          ld_r[ri] = 1'b1;
          LD_SR    = 1'b1;
        end else if (op == OP_COPY) begin
          IB0_SEL  = rj;
          ld_r[ri] = 1'b1;
        end else if (op == OP_STK) begin
          case (rj)
            2'd0: begin
              IB0_SEL = ri;
              push    = 1'b1;
            end
            2'd1: begin
              IB2_SEL  = 2'd3;
              ipstksel = 1'b1;
              pop      = 1'b1;
              ld_r[ri] = 1'b1;
            end
            2'd2: begin
              IB2_SEL  = 2'd3;
              ld_r[ri] = 1'b1;
            end
            default: begin
              IB0_SEL = ri;
              LD_OPDR = 1'b1;
            end
          endcase
        end
      end
      S_ADDR: begin
        LD_MAR  = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        state_d = S_FETCH;
        if (op == OP_LOAD) begin
          IB2_SEL  = (MARout == IPDR_ADDR) ? 2'd3 : 2'd2;
          ld_r[ri] = 1'b1;
        end else if (op == OP_STORE) begin
          IB0_SEL = ri;
          if (MARout == OPDR_ADDR) LD_OPDR = 1'b1;
          else                     RW      = 1'b1;
        end
      end
      S_JCHK: begin
        if (cond) begin
          LD_MAR  = 1'b1;
          state_d = S_JLD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_JLD: begin
        LD_PC   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign LD_R0 = ld_r[0];
  assign LD_R1 = ld_r[1];
  assign LD_R2 = ld_r[2];
  assign LD_R3 = ld_r[3];
  assign state = state_q;

endmodule

// File: tb/tb_cjb_risc_hmmiop_cu_v.sv
// Testbench for cjb_risc_hmmiop_cu_v: per-instruction reference model
// feeds a per-cycle scoreboard, monitor compares on the falling edge.
module tb_cjb_risc_hmmiop_cu_v;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] IW;
  logic [3:0] SR_CNVZ;
  logic [9:0] MARout;
  logic RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3;
  logic LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR;
  logic push, pop, ipstksel;
  logic [1:0] IB0_SEL, IB1_SEL, IB2_SEL;
  logic [3:0] ALU_FS;
  logic [3:0] state;

  cjb_risc_hmmiop_cu_v dut (
    .Clock(Clock), .Reset(Reset), .IW(IW), .SR_CNVZ(SR_CNVZ),
    .MARout(MARout), .RST_PC(RST_PC), .LD_PC(LD_PC),
    .CNT_PC(CNT_PC), .LD_IR(LD_IR), .LD_R0(LD_R0),
    .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3),
    .LD_SR(LD_SR), .LD_MABR(LD_MABR), .LD_MAXR(LD_MAXR),
    .LD_MAR(LD_MAR), .RW(RW), .LD_IPDR(LD_IPDR),
    .LD_OPDR(LD_OPDR), .push(push), .pop(pop),
    .ipstksel(ipstksel), .IB0_SEL(IB0_SEL), .IB1_SEL(IB1_SEL),
    .IB2_SEL(IB2_SEL), .ALU_FS(ALU_FS), .state(state)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       rst_pc, ld_pc, cnt_pc, ld_ir;
    logic [3:0] ld_r;
    logic       ld_sr, ld_mabr, ld_maxr, ld_mar;
    logic       rw, ld_ipdr, ld_opdr, push, pop, ipstksel;
    logic [1:0] ib0, ib1, ib2;
    logic [3:0] fs;
    logic [3:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t seq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.rst_pc = RST_PC;  a.ld_pc = LD_PC;
    a.cnt_pc = CNT_PC;  a.ld_ir = LD_IR;
    a.ld_r   = {LD_R3, LD_R2, LD_R1, LD_R0};
    a.ld_sr  = LD_SR;   a.ld_mabr = LD_MABR;
    a.ld_maxr = LD_MAXR; a.ld_mar = LD_MAR;
    a.rw     = RW;      a.ld_ipdr = LD_IPDR;
    a.ld_opdr = LD_OPDR; a.push = push; a.pop = pop;
    a.ipstksel = ipstksel;
    a.ib0 = IB0_SEL; a.ib1 = IB1_SEL; a.ib2 = IB2_SEL;
    a.fs  = ALU_FS;  a.st = state;
    return a;
  endfunction

  // Monitor: one expected record per cycle while the scoreboard holds any
  always @(negedge Clock) begin
    exp_t e, a;
    cyc = cyc + 1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = sample();
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL cyc%0d state/ctl act=%h exp=%h (st act=%0d exp=%0d)",
                 cyc, a, e, a.st, e.st);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Reference model: whole-instruction expected cycle list
  task automatic gen(input logic [7:0] iw, input logic [3:0] sr,
                     input logic [9:0] mar, input int halt_n);
    exp_t e;
    int op, ri, rj, c;
    bit taken;
    op = int'(iw[7:4]);
    ri = int'(iw[3:2]);
    rj = int'(iw[1:0]);
    c  = int'(iw[3:0]);
    seq.delete();
    e = mk(4'd1);
    e.ld_ir = 1; e.cnt_pc = 1; e.ld_ipdr = 1;
    seq.push_back(e);
    e = mk(4'd2);
    if (op == 1 || op == 2 || op == 13) begin
      e.ld_mabr = 1; e.ld_maxr = 1; e.cnt_pc = 1;
      if (op != 13) e.ib0 = 2'(rj);
    end
    seq.push_back(e);
    if (op == 14) begin
      for (int i = 0; i < halt_n; i++) seq.push_back(mk(4'd8));
    end else if (op == 1 || op == 2) begin
      e = mk(4'd4);
      e.ld_mar = 1;
      seq.push_back(e);
      e = mk(4'd5);
      if (op == 1) begin
        e.ld_r[ri] = 1;
        e.ib2 = (mar == 10'h3FF) ? 2'd3 : 2'd2;
      end else begin
        e.ib0 = 2'(ri);
        if (mar == 10'h3FE) e.ld_opdr = 1;
        else                e.rw = 1;
      end
      seq.push_back(e);
    end else if (op == 13) begin
      if (c == 0)                taken = 1;
      else if (c >= 1 && c <= 4) taken = sr[4 - c];
      else if (c >= 5 && c <= 8) taken = !sr[8 - c];
      else                       taken = 0;
      e = mk(4'd6);
      e.ld_mar = taken;
      seq.push_back(e);
      if (taken) begin
        e = mk(4'd7);
        e.ld_pc = 1;
        seq.push_back(e);
      end
    end else begin
      e = mk(4'd3);
      if (op >= 4 && op <= 11) begin
        e.ib0 = 2'(ri); e.ib1 = 2'(rj); e.ib2 = 2'd1;
        e.fs  = 4'(op - 4);
        e.ld_r[ri] = 1; e.ld_sr = 1;
      end else if (op == 3) begin
        e.ib0 = 2'(rj); e.ld_r[ri] = 1;
      end else if (op == 12) begin
        if (rj == 0) begin
          e.ib0 = 2'(ri); e.push = 1;
        end else if (rj == 1) begin
          e.ib2 = 2'd3; e.ipstksel = 1; e.pop = 1; e.ld_r[ri] = 1;
        end else if (rj == 2) begin
          e.ib2 = 2'd3; e.ld_r[ri] = 1;
        end else begin
          e.ib0 = 2'(ri); e.ld_opdr = 1;
        end
      end
      seq.push_back(e);
    end
  endtask

  task automatic issue(input logic [7:0] iw, input logic [3:0] sr,
                       input logic [9:0] mar, input int halt_n,
                       input int keep);
    int n;
    IW = iw; SR_CNVZ = sr; MARout = mar;
    gen(iw, sr, mar, halt_n);
    n = (keep > 0 && keep < seq.size()) ? keep : seq.size();
    for (int i = 0; i < n; i++) sb_q.push_back(seq[i]);
    wait_cyc(n);
  endtask

  task automatic do_reset(input int hold);
    exp_t e;
    e = mk(4'd0);
    e.rst_pc = 1;
    Reset = 1'b1;
    for (int i = 0; i < hold; i++) sb_q.push_back(e);
    wait_cyc(hold);
    Reset = 1'b0;
    sb_q.push_back(e);
    wait_cyc(1);
  endtask

  initial begin
    logic [7:0] iw;
    logic [9:0] mar;
    Reset = 1'b1; IW = 8'h00; SR_CNVZ = 4'h0; MARout = 10'h000;
    @(posedge Clock);
    #1;
    do_reset(3);
    issue(8'h46, 4'h0, 10'h000, 0, 0);
    issue(8'h13, 4'h0, 10'h3FF, 0, 0);
    issue(8'h13, 4'h0, 10'h123, 0, 0);
    issue(8'h24, 4'h0, 10'h3FE, 0, 0);
    issue(8'h24, 4'h0, 10'h010, 0, 0);
    issue(8'hD4, 4'b0001, 10'h000, 0, 0);
    issue(8'hD4, 4'b0000, 10'h000, 0, 0);
    issue(8'hD0, 4'b0000, 10'h000, 0, 0);
    issue(8'hDF, 4'b1111, 10'h000, 0, 0);
    issue(8'hC4, 4'h0, 10'h000, 0, 0);
    issue(8'hC9, 4'h0, 10'h000, 0, 0);
    issue(8'hCE, 4'h0, 10'h000, 0, 0);
    issue(8'hC3, 4'h0, 10'h000, 0, 0);
    issue(8'h3B, 4'h0, 10'h000, 0, 0);
    issue(8'hBF, 4'h0, 10'h000, 0, 0);
    issue(8'h00, 4'h0, 10'h000, 0, 0);
    issue(8'hF5, 4'h0, 10'h000, 0, 0);
    issue(8'hE0, 4'h0, 10'h000, 20, 0);
    do_reset(2);
    issue(8'h13, 4'h0, 10'h3FF, 0, 3);
    do_reset(1);
    for (int k = 0; k < 150; k++) begin
      iw = 8'($urandom_range(0, 255));
      if (iw[7:4] == 4'hE) iw[7:4] = 4'(k % 14);
      case ($urandom_range(0, 3))
        0:       mar = 10'h3FF;
        1:       mar = 10'h3FE;
        default: mar = 10'($urandom_range(0, 1023));
      endcase
      issue(iw, 4'($urandom_range(0, 15)), mar, 0, 0);
    end
    wait_cyc(2);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending act=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
